// File: rtl/seq_normalizer_if.sv
// Start/done handshake and result bus for seq_normalizer.
interface seq_normalizer_if #(
    parameter int unsigned W = 32
);
    localparam int unsigned CW = 5;

    logic          start;
    logic [W-1:0]  inp_norm;
    logic          busy;
    logic          done;
    logic [W-1:0]  out_norm;
    logic [CW-1:0] shamt;
    logic          zero;

    modport master (
        output start, inp_norm,
        input  busy, done, out_norm, shamt, zero
    );

    modport slave (
        input  start, inp_norm,
        output busy, done, out_norm, shamt, zero
    );
endinterface

// File: rtl/seq_normalizer.sv
// Multi-cycle left-normalizer: finds the leading-zero count and the operand shifted so its leading 1 sits at the MSB.
// Optional NORM_NIBBLE_EN: skip four zero bits per cycle while the top nibble is clear.
module seq_normalizer #(
    parameter int unsigned W = 32
) (
    input  logic                clk,
    input  logic                reset,
    seq_normalizer_if.slave     bus
);
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [W-1:0]  working, working_n;
    logic [CW-1:0] count, count_n;
    logic [W-1:0]  out_norm_q, out_norm_n;
    logic [CW-1:0] shamt_q, shamt_n;
    logic          zero_q, zero_n;
    logic          busy_q, done_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n    = state;
        working_n  = working;
        count_n    = count;
        out_norm_n = out_norm_q;
        shamt_n    = shamt_q;
        zero_n     = zero_q;

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    working_n = bus.inp_norm;
                    count_n   = '0;
                    if (bus.inp_norm == '0) begin
                        state_n    = DONE;
                        zero_n     = 1'b1;
                        shamt_n    = '0;
                        out_norm_n = '0;
                    end else begin
                        state_n = SHIFT;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
`ifdef NORM_NIBBLE_EN
                if (working[W-1 -: 4] == 4'b0000) begin
                    working_n = working << 4;
                    count_n   = count + CW'(4);
                end else
`endif
                if (working[W-1]) begin
                    state_n    = DONE;
                    out_norm_n = working;
                    shamt_n    = count;
                    zero_n     = 1'b0;
                end else begin
                    working_n = working << 1;
                    count_n   = count + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            working    <= '0;
            count      <= '0;
            out_norm_q <= '0;
            shamt_q    <= '0;
            zero_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            working    <= working_n;
            count      <= count_n;
            out_norm_q <= out_norm_n;
            shamt_q    <= shamt_n;
            zero_q     <= zero_n;
            busy_q     <= (state_n == SHIFT);
            done_q     <= (state_n == DONE);
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.out_norm = out_norm_q;
    assign bus.shamt    = shamt_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_seq_normalizer.sv
// Randomized self-checking bench for seq_normalizer against a leading-zero reference model.
module tb_seq_normalizer;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_normalizer_if #(.W(W)) bus ();

    seq_normalizer #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] res_norm;
    logic [31:0] res_shamt;
    logic [31:0] res_zero;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lz(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) return 31 - i;
        end
        return 32;
    endfunction

    function automatic int latency(input int k);
        if (k == 32) return 0;
`ifdef NORM_NIBBLE_EN
        return k / 4 + k % 4 + 1;
`else
        return k + 1;
`endif
    endfunction

    // Called #1 after an edge; the request is sampled at the next edge.
    task automatic launch(input logic [31:0] v);
        bus.start    = 1'b1;
        bus.inp_norm = v;
    endtask

    // noise: 0 none, 1 random stray starts while busy, 2 one 0xFFFFFFFF start on the third busy cycle
    task automatic finish_op(input logic [31:0] v, input int noise);
        int k;
        int n;
        int bcnt;
        k    = lz(v);
        n    = 0;
        bcnt = 0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (!bus.done && n < 200) begin
            check("hold_norm", bus.out_norm, res_norm);
            check("hold_shamt", 32'(bus.shamt), res_shamt);
            if (bus.busy) bcnt++;
            bus.start = 1'b0;
            if (bus.busy && ((noise == 1 && $urandom_range(0, 3) == 0) || (noise == 2 && n == 2))) begin
                bus.start    = 1'b1;
                bus.inp_norm = (noise == 2) ? 32'hFFFF_FFFF : $urandom;
            end
            @(posedge clk); #1;
            n++;
        end
        bus.start = 1'b0;
        res_zero  = (k == 32) ? 32'd1 : 32'd0;
        res_shamt = (k == 32) ? 32'd0 : 32'(k);
        res_norm  = (k == 32) ? 32'd0 : (v << k);
        check("latency", 32'(n), 32'(latency(k)));
        check("busy_cycles", 32'(bcnt), 32'(latency(k)));
        check("busy_with_done", 32'(bus.busy), 32'd0);
        check("out_norm", bus.out_norm, res_norm);
        check("shamt", 32'(bus.shamt), res_shamt);
        check("zero", 32'(bus.zero), res_zero);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_norm", bus.out_norm, res_norm);
        check("idle_shamt", 32'(bus.shamt), res_shamt);
        check("idle_zero", 32'(bus.zero), res_zero);
    endtask

    task automatic op(input logic [31:0] v, input int noise);
        launch(v);
        finish_op(v, noise);
    endtask

    initial begin
        int dones;
        int k;
        logic [31:0] v;
        logic [31:0] top;

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.inp_norm = '0;
        res_norm     = '0;
        res_shamt    = '0;
        res_zero     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_norm", bus.out_norm, 32'd0);
        check("rst_shamt", 32'(bus.shamt), 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed boundary cases
        op(32'h8000_0000, 0);
        idle_cycle();
        op(32'h0000_0001, 0);
        idle_cycle();
        op(32'h0000_0000, 0);
        idle_cycle();
        op(32'h0001_2345, 2);
        check("dir_ignored_shamt", res_shamt, 32'd15);
        op(32'h00F0_0000, 0);
        idle_cycle();

        // Reset on the fifth busy cycle aborts without a done pulse
        launch(32'h0000_0100);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_norm", bus.out_norm, 32'd0);
        check("abort_shamt", 32'(bus.shamt), 32'd0);
        check("abort_zero", 32'(bus.zero), 32'd0);
        res_norm  = '0;
        res_shamt = '0;
        res_zero  = '0;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) dones++;
        end
        check("abort_quiet", 32'(dones), 32'd0);
        op(32'h0000_0100, 0);
        idle_cycle();

        // Random operands over every leading-zero count, random back-to-back and stray starts
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 32);
            if (k == 32) begin
                v = '0;
            end else begin
                top = 32'h8000_0000 >> k;
                v   = top | ($urandom & (top - 32'd1));
            end
            op(v, 1);
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_normalizer.md
Name: seq_normalizer

Overview:
- Multi-cycle left-normalizer; the inverse of the combinational shifter.
- Takes an operand and finds the shift amount that moves its leading 1 to the MSB.
- Returns both the shift amount and the normalized value.
- Sits beside the ALU/shifter datapath and feeds CLZ-style results and normalized operands back into it.
- Uses a start/done handshake and iterates one bit (optionally four bits) per clock.

Parameters:
- W, default 32: operand width. Legal range 4..32, so the shift count always fits in 5 bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only when the block is accepting (state IDLE or DONE).
- inp_norm  input  W  operand. Captured on the accept edge.
- busy  output  1  high while state is SHIFT.
- done  output  1  one-cycle pulse; results are valid from this cycle.
- out_norm  output  W  normalized value, equal to inp_norm << shamt.
- shamt  output  5  number of leading zeros of the operand.
- zero  output  1  operand was all zeros.

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous and active-high (reset). All state changes on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, out_norm=0, shamt=0, zero=0. Reset asserted mid-operation aborts the operation at that edge; no done pulse is produced for it.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 is accepted.
  - Capture inp_norm into the working register and clear the count.
  - If inp_norm==0: go to DONE with zero=1, shamt=0, out_norm=0.
  - Otherwise: go to SHIFT with zero=0.
- SHIFT:
  - If working[W-1]==1: go to DONE, load out_norm=working and shamt=count.
  - Otherwise: working <<= 1 and count += 1.
  - start is ignored while busy.
  - The loop always terminates because the working value is nonzero.
- DONE:
  - done=1 for exactly this cycle.
  - Next state is IDLE, unless start=1 in this cycle. A start here is accepted exactly as in IDLE, which allows back-to-back operations.
- Latency, counted as N = edges after the accept edge until done is visible:
  - N = k+1 for k leading zeros.
  - N = 0 for a zero operand.
- Output hold: out_norm, shamt and zero hold their values until the next DONE entry, and are unchanged while busy. done is never high in the same cycle as busy.
- Width rules: the count is 5 bits. Maximum shamt is W-1 (31 for W=32), so the count never wraps. The working register shifts in zeros.

Optional Feature:
- Macro: NORM_NIBBLE_EN.
- When defined, SHIFT also checks working[W-1:W-4]:
  - If it is 0: working <<= 4 and count += 4 in one cycle.
  - Else if working[W-1]==0: single-bit shift as above.
  - Else: go to DONE.
- Results are identical with or without the macro; only the latency changes.
  - With the macro: N = floor(k/4) + (k mod 4) + 1.
  - Without the macro: N = k+1, as above.

Test Plan (W=32):
- Start with inp_norm=0x8000_0000 -> done after N=1 edges; shamt=0, out_norm=0x8000_0000, zero=0, busy high for exactly 1 cycle.
- Start with inp_norm=0x0000_0001 -> without the macro: done after 32 edges, shamt=31, out_norm=0x8000_0000. With NORM_NIBBLE_EN: done after 11 edges, same results.
- Start with inp_norm=0 -> done after 0 edges (the cycle after accept); zero=1, shamt=0, out_norm=0, busy never asserted.
- Start with 0x0001_2345, and while busy pulse start with 0xFFFF_FFFF -> the second request is ignored; result shamt=15, out_norm=0x91A2_8000. Then start in the DONE cycle with 0x00F0_0000 -> accepted back-to-back; shamt=8, out_norm=0xF000_0000.
- Start with 0x0000_0100, then assert reset on the 5th busy cycle -> the next edge shows state IDLE and all outputs 0. No done pulse occurs, and a new start behaves normally.
